// File: rtl/issue_queue_pkg.sv
// Shared types for the decode -> issue queue: the decoded element layout and
// the default queue depth used by the core.
package issue_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef logic bool;

    typedef enum logic [2:0] {
        EXE_ALU = 3'd0,
        EXE_MUL = 3'd1,
        EXE_DIV = 3'd2,
        EXE_LSU = 3'd3,
        EXE_BRU = 3'd4,
        EXE_CSR = 3'd5
    } exe_type_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        exe_type_t   exe_type;
        bool         write_reg_need;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ISSUE_QUEUE_ELEMENT;

    // Issue may ask for more entries than are presented; never retire more than exist.
    function automatic logic [1:0] clamp_pop(input logic [1:0] req, input logic [1:0] avail);
        return (req > avail) ? avail : req;
    endfunction

endpackage

// File: rtl/issue_queue.sv
// Dual-lane in-order FIFO between decode and issue: up to two pushes and two
// pops per cycle, head pair presented zero-filled when not valid.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flash,
    input  logic                     stall,
    input  logic [1:0]               push_valid,
    input  ISSUE_QUEUE_ELEMENT [1:0] push_data,
    output logic                     push_ready,
    output ISSUE_QUEUE_ELEMENT [1:0] issue_require,
    output logic [1:0]               iq_size,
    input  logic [1:0]               iq_pop_number,
    output logic [PTR_W:0]           iq_count
);

    ISSUE_QUEUE_ELEMENT mem [DEPTH];

    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [PTR_W-1:0]   rd_ptr_p1, wr_ptr_p1;
    logic [PTR_W:0]     count;
    logic [1:0]         n_push, n_pop;
    ISSUE_QUEUE_ELEMENT wdata0;

    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
    assign wr_ptr_p1 = wr_ptr + PTR_W'(1);

    assign iq_size    = (count >= (PTR_W+1)'(2)) ? 2'd2 : count[1:0];
    assign push_ready = (count <= (PTR_W+1)'(DEPTH - 2));
    assign iq_count   = count;

    assign n_push = push_ready ? (2'(push_valid[0]) + 2'(push_valid[1])) : 2'd0;
    assign n_pop  = stall ? 2'd0 : clamp_pop(iq_pop_number, iq_size);

    // Zero-fill invalid head slots so issue never acts on stale fields.
    assign issue_require[0] = (iq_size != 2'd0) ? mem[rd_ptr]    : '0;
    assign issue_require[1] = (iq_size == 2'd2) ? mem[rd_ptr_p1] : '0;

    // Lanes are compacted: a lone lane-1 push lands at the tail.
    assign wdata0 = push_valid[0] ? push_data[0] : push_data[1];

    always_ff @(posedge clk) begin
        if (!flash && n_push != 2'd0) begin
            mem[wr_ptr] <= wdata0;
            if (n_push == 2'd2)
                mem[wr_ptr_p1] <= push_data[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flash) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(n_pop);
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            count  <= count + (PTR_W+1)'(n_push) - (PTR_W+1)'(n_pop);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && !flash)
            assert ((int'(count) + int'(n_push) - int'(n_pop) >= 0) &&
                    (int'(count) + int'(n_push) - int'(n_pop) <= DEPTH))
            else $error("issue_queue occupancy out of range");
    end
`endif

endmodule
